// File: rtl/apb_slave_mem_ws.sv
// APB register-bank slave: DEPTH words of DATA_W bits, byte strobes, optional
// wait states before PREADY and PSLVERR on out-of-range or misaligned access.

module apb_slave_mem_ws_lane #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       wd_i,
  output logic [7:0]       rd_o
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wd_i;
  end

  assign rd_o = mem_q[idx_i];
endmodule

module apb_slave_mem_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);
  localparam int NB    = DATA_W / 8;
  localparam int OFS   = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS) - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q;
  logic                   wr_q;
  logic [NB-1:0][7:0]     wdata_q;
  logic [NB-1:0]          strb_q;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [DATA_W-1:0]      prdata_q, prdata_d;
  logic                   cap;
  logic                   acc_go;

  // Accesses without wait states use the live bus; otherwise the captured copy.
  logic                   live;
  logic [ADDR_W-1:0]      a_addr;
  logic                   a_wr;
  logic [NB-1:0][7:0]     a_wdata;
  logic [NB-1:0]          a_strb;
  logic [ADDR_W-1:0]      widx;
  logic [IDX_W-1:0]       word;
  logic                   a_err;
  logic [NB-1:0]          lane_we;
  logic [NB-1:0][7:0]     rdata;

  assign live    = (state_q == S_IDLE);
  assign a_addr  = live ? PADDR  : addr_q;
  assign a_wr    = live ? PWRITE : wr_q;
  assign a_wdata = live ? PWDATA : wdata_q;
  assign a_strb  = live ? PSTRB  : strb_q;
  assign widx    = a_addr >> OFS;
  assign word    = widx[IDX_W-1:0];
  assign a_err   = ({1'b0, widx} >= DEPTH_A) || (|(a_addr & OFS_MASK));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    cap       = 1'b0;
    acc_go    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && PENABLE) begin
          cap = 1'b1;
          if (WAIT_STATES == 0) begin
            acc_go  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!(PSEL && PENABLE)) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          acc_go  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (acc_go) begin
      pready_d  = 1'b1;
      pslverr_d = a_err;
      if (!a_wr) prdata_d = a_err ? '0 : rdata;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (cap) begin
      addr_q  <= PADDR;
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // Reset blocks the write so an interrupted transfer leaves memory untouched.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_we[i] = PRESETn && acc_go && a_wr && !a_err && a_strb[i];
    apb_slave_mem_ws_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk_i (PCLK),
      .we_i  (lane_we[i]),
      .idx_i (word),
      .wd_i  (a_wdata[i]),
      .rd_o  (rdata[i])
    );
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Scoreboard bench for apb_slave_mem_ws: three instances (32b/0ws, 32b/3ws,
// 64b/0ws) share one bus; each transfer selects one of them via its PSEL.
module tb_apb_slave_mem_ws;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [2:0]  psel;
  logic        PENABLE, PWRITE;
  logic [7:0]  paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  logic [2:0]  rdy, err;

  typedef struct {
    int          k;
    bit          err;
    logic [63:0] d;
    string       nm;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [63:0] last[3];
  int          ws[3] = '{0, 3, 0};
  int          total = 0;
  int          bad   = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_mem_ws #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
    .PRDATA(rd0), .PREADY(rdy[0]), .PSLVERR(err[0]));
  apb_slave_mem_ws #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
    .PRDATA(rd1), .PREADY(rdy[1]), .PSLVERR(err[1]));
  apb_slave_mem_ws #(.DATA_W(64), .ADDR_W(8), .DEPTH(8), .WAIT_STATES(0)) u_w64 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(rd2), .PREADY(rdy[2]), .PSLVERR(err[2]));

  function automatic logic [63:0] rdk(input int k);
    case (k)
      0:       return {32'h0, rd0};
      1:       return {32'h0, rd1};
      default: return rd2;
    endcase
  endfunction

  // Monitor: every PREADY pulse must match the oldest queued expectation.
  always @(negedge PCLK) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy[k] === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pready dut%0d err=%0b data=%h", k, err[k], rdk(k));
        end else begin
          mon_e = q.pop_front();
          if (mon_e.k != k || err[k] !== mon_e.err || rdk(k) !== mon_e.d) begin
            bad++;
            $display("FAIL %s: got dut%0d err=%0b data=%h, want dut%0d err=%0b data=%h",
                     mon_e.nm, k, err[k], rdk(k), mon_e.k, mon_e.err, mon_e.d);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic apb(input int k, input bit wr, input logic [7:0] a, input logic [63:0] wd,
                     input logic [7:0] st, input bit eerr, input logic [63:0] erd,
                     input string nm);
    exp_t e;
    int   n;
    @(posedge PCLK); #1;
    psel = 3'b000; psel[k] = 1'b1;
    PWRITE = wr; paddr = a; pwdata = wd; pstrb = st; PENABLE = 1'b0;
    if (!wr) last[k] = eerr ? 64'h0 : erd;
    e.k = k; e.err = eerr; e.d = last[k]; e.nm = nm;
    q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(posedge PCLK); #1;
      n++;
    end while (rdy[k] !== 1'b1 && n < 40);
    chk({nm, "_latency"}, 64'(n), 64'(ws[k] + 1));
    @(posedge PCLK); #1;
    psel = 3'b000; PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; psel = 3'b000; PENABLE = 1'b0; PWRITE = 1'b0;
    paddr = 8'h0; pwdata = 64'h0; pstrb = 8'h0;
    last[0] = 64'h0; last[1] = 64'h0; last[2] = 64'h0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_rdy",  {61'h0, rdy}, 64'h0);
    chk("rst_err",  {61'h0, err}, 64'h0);
    chk("rst_rd0",  {32'h0, rd0}, 64'h0);
    chk("rst_rd1",  {32'h0, rd1}, 64'h0);
    chk("rst_rd2",  rd2, 64'h0);
    PRESETn = 1'b1;

    // 32-bit, no wait states
    apb(0, 1, 8'h08, 64'hDEADBEEF, 8'hF, 0, 0, "w0_wr08");
    apb(0, 0, 8'h08, 0, 8'h0, 0, 64'hDEADBEEF, "w0_rd08");
    apb(0, 1, 8'h0C, 64'hFFFFFFFF, 8'hF, 0, 0, "w0_wr0c_ff");
    apb(0, 1, 8'h0C, 64'h12345678, 8'h5, 0, 0, "w0_wr0c_strb5");
    apb(0, 0, 8'h0C, 0, 8'h0, 0, 64'hFF34FF78, "w0_rd0c");
    apb(0, 0, 8'h40, 0, 8'h0, 1, 0, "w0_rd40_oob");
    apb(0, 1, 8'h00, 64'hCAFEF00D, 8'hF, 0, 0, "w0_wr00");
    apb(0, 1, 8'h41, 64'h99999999, 8'hF, 1, 0, "w0_wr41_mis");
    apb(0, 0, 8'h00, 0, 8'h0, 0, 64'hCAFEF00D, "w0_rd00");
    apb(0, 1, 8'h3C, 64'h0F0F0F0F, 8'hF, 0, 0, "w0_wr3c_last");
    apb(0, 0, 8'h3C, 0, 8'h0, 0, 64'h0F0F0F0F, "w0_rd3c_last");
    apb(0, 0, 8'h0A, 0, 8'h0, 1, 0, "w0_rd0a_mis");

    // 32-bit, three wait states
    apb(1, 1, 8'h08, 64'hA5A5A5A5, 8'hF, 0, 0, "w3_wr08");
    apb(1, 0, 8'h08, 0, 8'h0, 0, 64'hA5A5A5A5, "w3_rd08");
    apb(1, 1, 8'h04, 64'h11223344, 8'hF, 0, 0, "w3_wr04");
    apb(1, 0, 8'h04, 0, 8'h0, 0, 64'h11223344, "w3_rd04");

    // Reset held through the edge where the write would have landed
    @(posedge PCLK); #1;
    psel = 3'b010; PWRITE = 1'b1; paddr = 8'h04; pwdata = 64'hAAAAAAAA; pstrb = 8'hF;
    PENABLE = 1'b0;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1; PRESETn = 1'b0;
    @(posedge PCLK); #1;
    chk("midrst_rdy", {63'h0, rdy[1]}, 64'h0);
    chk("midrst_err", {63'h0, err[1]}, 64'h0);
    chk("midrst_rd1", {32'h0, rd1}, 64'h0);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    psel = 3'b000; PENABLE = 1'b0; PRESETn = 1'b1;
    last[0] = 64'h0; last[1] = 64'h0; last[2] = 64'h0;
    apb(1, 0, 8'h04, 0, 8'h0, 0, 64'h11223344, "w3_rd04_after_rst");

    // Abort: PSEL dropped during the wait phase
    @(posedge PCLK); #1;
    psel = 3'b010; PWRITE = 1'b0; paddr = 8'h08; PENABLE = 1'b0;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1; psel = 3'b000; PENABLE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); #1;
      chk("abort_no_rdy", {63'h0, rdy[1]}, 64'h0);
    end
    apb(1, 0, 8'h08, 0, 8'h0, 0, 64'hA5A5A5A5, "w3_rd08_after_abort");

    // 64-bit, depth 8
    apb(2, 1, 8'h08, 64'h0123456789ABCDEF, 8'hFF, 0, 0, "w64_wr08");
    apb(2, 0, 8'h08, 0, 8'h0, 0, 64'h0123456789ABCDEF, "w64_rd08");
    apb(2, 1, 8'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 0, "w64_wr10_ff");
    apb(2, 1, 8'h10, 64'h1122334455667788, 8'h55, 0, 0, "w64_wr10_strb55");
    apb(2, 0, 8'h10, 0, 8'h0, 0, 64'hFF22FF44FF66FF88, "w64_rd10");
    apb(2, 0, 8'h40, 0, 8'h0, 1, 0, "w64_rd40_oob");
    apb(2, 1, 8'h38, 64'h00000000C0FFEE00, 8'hFF, 0, 0, "w64_wr38_last");
    apb(2, 0, 8'h38, 0, 8'h0, 0, 64'h00000000C0FFEE00, "w64_rd38_last");
    apb(2, 0, 8'h0C, 0, 8'h0, 1, 0, "w64_rd0c_mis");

    repeat (4) @(posedge PCLK);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem_ws.md
Name: apb_slave_mem_ws

Overview:
Parametrised APB slave with word-organised register memory, configurable wait states, byte-lane write strobes and PSLVERR. It generalises the team's fixed 8x32 APB memory slave in width, depth and timing, and adds error reporting. It sits on the APB bus behind the bridge as a scratch/config register bank.

Parameters:
DATA_W, 32, data bus width in bits; legal values 8/16/32/64.
ADDR_W, 8, PADDR width in bits (byte address).
DEPTH, 16, number of DATA_W-bit words; must satisfy DEPTH*(DATA_W/8) <= 2^ADDR_W.
WAIT_STATES, 0, extra access-phase cycles inserted before PREADY; range 0..15.

Ports:
PCLK  in  1  clock; all logic on rising edge.
PRESETn  in  1  synchronous reset, active-low.
PSEL  in  1  slave select.
PENABLE  in  1  access-phase indicator.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_W  byte address.
PWDATA  in  DATA_W  write data.
PSTRB  in  DATA_W/8  write byte-lane enables; ignored on reads.
PRDATA  out  DATA_W  read data, registered.
PREADY  out  1  transfer-complete, registered.
PSLVERR  out  1  transfer error, registered; meaningful only while PREADY=1.

Behaviour:
- Reset (PRESETn=0 at a clock edge): PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not reset. Reset wins over any in-flight transfer: no memory write, no response.
- OFS = log2(DATA_W/8) byte-offset bits. Word index = PADDR[ADDR_W-1:OFS].
- Error condition: word index >= DEPTH, or PADDR[OFS-1:0] != 0 (misaligned; no check when DATA_W=8).
- FSM states: IDLE, WAIT, RESP.
- IDLE: at an edge E0 with PSEL=1 and PENABLE=1, capture PADDR, PWRITE, PWDATA and PSTRB.
  - WAIT_STATES=0: perform the access at E0 and go to RESP.
  - WAIT_STATES>0: load the counter with WAIT_STATES and go to WAIT.
- WAIT: decrement the counter each edge. At the edge where the counter is 1, perform the access and go to RESP.
- WAIT abort: if PSEL=0 or PENABLE=0 at an edge while in WAIT (protocol violation), return to IDLE. No write, no response.
- "Perform access" (single edge):
  - PREADY<=1.
  - PSLVERR<=error.
  - Write with no error: each byte lane i with PSTRB[i]=1 updated from PWDATA; lanes with PSTRB[i]=0 unchanged.
  - Read with no error: PRDATA<=mem[index].
  - Read with error: PRDATA<=0.
  - Write with error: memory unchanged, PRDATA unchanged.
- Resulting timing: PREADY is visible from edge E0+WAIT_STATES; the master completes at edge E0+WAIT_STATES+1. The access phase lasts WAIT_STATES+2 cycles.
- RESP: next edge PREADY<=0, PSLVERR<=0, go to IDLE. PSEL/PENABLE still high at this edge are not treated as a new transfer.
- Back-to-back transfers: the next access can be accepted no earlier than 2 edges after the RESP edge (APB setup phase intervenes).
- PRDATA holds its last value between reads; writes never alter PRDATA.
- Outside the RESP cycle, PREADY=0 and PSLVERR=0 at all times.
- Memory is a plain register array (DEPTH x DATA_W); no read-during-write hazard, since one access is performed per transfer.

Test Plan:
1. Defaults (DATA_W=32, DEPTH=16, WAIT_STATES=0): write 0xDEADBEEF to PADDR 0x08 with PSTRB=0xF, then read 0x08 -> PREADY high exactly 1 cycle per transfer (2-cycle access phase); PRDATA=0xDEADBEEF; PSLVERR=0.
2. Byte strobes: write 0xFFFFFFFF to 0x0C, then write 0x12345678 with PSTRB=0x5, then read -> PRDATA=0xFF34FF78.
3. WAIT_STATES=3: read 0x08 -> PREADY low for 4 access cycles, high on the 5th; memory data returned correctly.
4. Errors: read PADDR 0x40 (index 16) -> PSLVERR=1, PRDATA=0. Write to 0x41 (misaligned) -> PSLVERR=1; word 16 nonexistent and word 0 unchanged on readback.
5. Reset mid-transfer (WAIT_STATES=3): drive PRESETn=0 during WAIT of a write to 0x04 -> PREADY/PSLVERR/PRDATA=0, no write. After release, reading 0x04 returns its prior value.
6. Abort and parameter sweep: drop PSEL during WAIT -> FSM returns to IDLE with no PREADY pulse. Repeat scenarios 1–2 with DATA_W=64, DEPTH=8 (PSTRB 8 bits, OFS=3).
